// File: rtl/mlp_weight_mem_if.sv
// Weight RAM bus: shared address, write strobe/data, async read data.
// master drives addr/wr_en/wr_data; slave returns rd_data.
interface mlp_weight_mem_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output addr,
    output wr_en,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/mlp_weight_mem.sv
// Single-port MLP weight RAM: sync write, async read, per-word valid bits.
// Ports: clk, rst (async active-low), bus (slave: addr/wr_en/wr_data/rd_data).
module mlp_weight_mem #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  mlp_weight_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  // No reset on the array so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (rst && bus.wr_en) begin
      mem[bus.addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (bus.wr_en) begin
      valid[bus.addr] <= 1'b1;
    end
  end

  // Gate on rst too, so reads are zero the instant reset asserts.
  always_comb begin
    bus.rd_data = '0;
    if (rst && valid[bus.addr]) begin
      bus.rd_data = mem[bus.addr];
    end
  end
endmodule

// File: tb/tb_mlp_weight_mem.sv
// Directed bench for mlp_weight_mem with a queue scoreboard.
// Expected read values come from a bench-side model of the RAM.
module tb_mlp_weight_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mlp_weight_mem_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  mlp_weight_mem #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model [64];
  bit          mv    [64];
  logic [31:0] sb    [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] exp_rd(input int a);
    if (!rst || !mv[a]) return 32'h0;
    return model[a];
  endfunction

  task automatic check(input string tag);
    logic [31:0] e;
    e = sb.pop_front();
    n_cmp++;
    assert (bus.rd_data === e) else begin
      n_err++;
      $error("FAIL %s: rd_data=%h expected=%h", tag, bus.rd_data, e);
    end
  endtask

  task automatic rd(input int a, input string tag);
    bus.addr = a[5:0];
    #1;
    sb.push_back(exp_rd(a));
    check(tag);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.addr    = a[5:0];
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clk);
    if (rst) begin
      model[a] = d;
      mv[a]    = 1'b1;
    end
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic rst_on();
    rst = 1'b0;
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  initial begin
    bus.addr    = '0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    foreach (mv[i]) mv[i] = 1'b0;

    #1 rst_on();
    repeat (2) @(posedge clk);
    #1 rd(0, "in_reset");
    @(negedge clk);
    rst = 1'b1;
    rd(0, "post_rst_a0");

    wr(0, 32'hAAAA_AAAA);
    @(posedge clk);
    #1 rd(0, "wr_a0");

    wr(5, 32'hBEEF_BEEF);
    rd(5, "wr_a5");
    rd(0, "persist_a0");

    wr(63, 32'hC0DE_C0DE);
    rd(63, "wr_a63");
    rd(0, "a0_after_63");
    rd(5, "a5_after_63");

    @(negedge clk);
    bus.addr    = 6'd5;
    bus.wr_data = 32'h1234_5678;
    bus.wr_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rd(5, "no_wr_en");

    rd(10, "never_written");

    @(negedge clk);
    bus.addr    = 6'd5;
    bus.wr_data = 32'h5A5A_5A5A;
    bus.wr_en   = 1'b1;
    #1;
    sb.push_back(exp_rd(5));
    check("pre_edge_old");
    @(posedge clk);
    model[5] = 32'h5A5A_5A5A;
    #1;
    sb.push_back(exp_rd(5));
    check("post_edge_new");
    bus.wr_en = 1'b0;

    wr(5, 32'h0BAD_F00D);
    rd(5, "overwrite");

    @(posedge clk);
    #2 rst_on();
    rd(0, "async_rst_a0");
    rd(5, "async_rst_a5");
    rd(63, "async_rst_a63");

    wr(0, 32'h9999_9999);
    rd(0, "wr_in_rst");
    @(negedge clk);
    rst = 1'b1;
    rd(0, "post_rel_a0");
    rd(63, "post_rel_a63");
    wr(0, 32'h1111_1111);
    rd(0, "rewrite_a0");

    rst_on();
    @(posedge clk);
    @(negedge clk);
    bus.addr    = 6'd20;
    bus.wr_data = 32'h2020_2020;
    bus.wr_en   = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    model[20] = 32'h2020_2020;
    mv[20]    = 1'b1;
    #1 bus.wr_en = 1'b0;
    rd(20, "first_edge_wr");
    rd(0, "a0_after_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mlp_weight_mem.md
Name: mlp_weight_mem

Overview:
- Single-port weight storage RAM for the MLP datapath. Holds 2^ADDR_WIDTH words of DATA_WIDTH bits.
- The loader writes weights through it. Neuron/MAC stages read weights combinationally by address.
- Writes are synchronous; reads are asynchronous.
- Per-word valid tracking makes never-written words read as zero after reset.

Parameters:
- ADDR_WIDTH, 6, address width; depth = 2^ADDR_WIDTH words (64 by default).
- DATA_WIDTH, 32, word width in bits.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low (asserted when rst=0).
- addr  input  ADDR_WIDTH  shared read/write word address.
- wr_en  input  1  write enable, active-high, sampled on rising clk.
- wr_data  input  DATA_WIDTH  data written to mem[addr] when wr_en=1.
- rd_data  output  DATA_WIDTH  combinational read of word at addr.

Behaviour:
- Storage: array mem[0 .. 2^ADDR_WIDTH-1] of DATA_WIDTH bits, plus a valid bit per word.
- Every address in 0 .. 2^ADDR_WIDTH-1 is legal. There is no out-of-range case and no wrap logic.
- Reset, asserted (rst=0):
  - Asynchronously clears all valid bits immediately, without waiting for a clock edge.
  - mem contents are not cleared, so the array stays BRAM/LUTRAM-inferable.
  - While rst=0, rd_data = 0 for every address and writes are ignored.
- Write, with rst=1 and wr_en=1 at rising clk:
  - mem[addr] <= wr_data and valid[addr] <= 1.
  - Only the addressed word changes.
- No write, wr_en=0 at rising clk: memory and valid bits are unchanged, whatever the value of wr_data.
- Read, combinational with zero latency: rd_data = valid[addr] ? mem[addr] : 0.
  - A change on addr is reflected in rd_data within the same cycle, with no clock needed.
- Write/read same address in one cycle:
  - Before the edge, rd_data shows the old content.
  - Immediately after the write edge, rd_data shows the new wr_data (write-then-read, no extra latency).
- Overwrite: a later write to the same address replaces the earlier value. The last write wins.
- Reset mid-operation: a write whose edge coincides with rst=0 is dropped.
  - After release, all words read 0 until rewritten.
- Reset release: the first rising edge with rst=1 may perform a write.
- No handshake and no busy state. A new write can be issued every cycle.
- rd_data must never be X after reset has been applied at least once.

Test Plan:
- Reset then write 0xAAAAAAAA to addr 0 with wr_en=1 for one edge, then drop wr_en -> rd_data=0xAAAAAAAA at addr 0 on the next cycle.
- Write 0xBEEFBEEF to addr 5 -> rd_data=0xBEEFBEEF. Return addr to 0 with no write -> rd_data=0xAAAAAAAA (persistence; addr 0 unaffected by addr 5 write).
- Write 0xC0DEC0DE to max addr 63 -> rd_data=0xC0DEC0DE. Addrs 0 and 5 unchanged.
- addr=5, wr_data=0x12345678, wr_en=0 for two edges -> rd_data stays 0xBEEFBEEF.
- Read never-written addr 10 after reset -> rd_data=0x00000000 (not X).
- Assert rst=0 asynchronously mid-cycle after the writes above -> rd_data=0 immediately at addrs 0/5/63. A write attempted with rst=0 is ignored. After release, addr 0 reads 0 until rewritten; rewriting 0x11111111 reads back 0x11111111.
